ip4_ram_arb: RTL

- Parametrised multi-channel SRAM wrapper: num_ch requesters share one RAM array through a round-robin arbiter with req/gnt handshake.
- Supports single-port (one access per cycle) and two-port (one read plus one write per cycle) modes.
- Per-byte write enables, registered read data with per-channel valid, and same-address read/write forwarding.
- Sits between IP4 pipeline clients and the RAM array; replaces per-client RAM instances where storage is shared.

---
 rtl/ip4_ram_arb.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ip4_ram_arb.sv
`default_nettype none
// ============================================================================
// ip4_ram_arb : num_ch requesters share one RAM array via round-robin req/gnt
// Optional macro IP4_RAM_ARB_OREG_EN adds an output register stage (latency 2)
// Rev 1.0
// ============================================================================
module ip4_ram_arb #(
   parameter int ADDR_WIDTH = 10,
   parameter int NUM_WORDS  = 1 << ADDR_WIDTH,
   parameter int WORD_WIDTH = 32,
   parameter int BE_WIDTH   = (WORD_WIDTH - 1) / 8 + 1,
   parameter int NUM_CH     = 2,
   parameter int TWO_PORT   = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CH-1:0]                req,
   input  logic [NUM_CH-1:0]                we,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]     adr,
   input  logic [NUM_CH*BE_WIDTH-1:0]       be,
   input  logic [NUM_CH*WORD_WIDTH-1:0]     datai,
   output logic [NUM_CH-1:0]                gnt,
   output logic [NUM_CH-1:0]                rvalid,
   output logic [WORD_WIDTH-1:0]            datao
);
   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // First requester at or after ptr, found as the smallest wrapped distance.
   function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] mask,
                                                 input logic [PW-1:0] ptr);
      logic [NUM_CH-1:0] g;
      int best;
      int off;
      g    = '0;
      best = NUM_CH;
      for (int c = 0; c < NUM_CH; c++) begin
         off = (c + NUM_CH - int'(ptr)) % NUM_CH;
         if (mask[c] && (off < best)) begin
            best = off;
            g    = '0;
            g[c] = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic logic [PW-1:0] rr_next(input logic [NUM_CH-1:0] g);
      int sel;
      sel = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (g[c]) sel = c;
      end
      return PW'((sel + 1) % NUM_CH);
   endfunction

   logic [NUM_CH-1:0]     gnt_rd;
   logic [NUM_CH-1:0]     gnt_wr;

   generate
      if (TWO_PORT != 0) begin : g_two_port
         logic [PW-1:0] rr_rd;
         logic [PW-1:0] rr_wr;

         always_comb begin
            gnt_rd = rr_pick(req & ~we, rr_rd);
            gnt_wr = rr_pick(req & we, rr_wr);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               rr_rd <= '0;
               rr_wr <= '0;
            end else begin
               if (|gnt_rd) rr_rd <= rr_next(gnt_rd);
               if (|gnt_wr) rr_wr <= rr_next(gnt_wr);
            end
         end
      end else begin : g_one_port
         logic [PW-1:0]     rr;
         logic [NUM_CH-1:0] g_any;

         always_comb begin
            g_any  = rr_pick(req, rr);
            gnt_rd = g_any & ~we;
            gnt_wr = g_any & we;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               rr <= '0;
            end else if (|g_any) begin
               rr <= rr_next(g_any);
            end
         end
      end
   endgenerate

   assign gnt = gnt_rd | gnt_wr;

   logic                  rd_fire;
   logic                  wr_fire;
   logic [ADDR_WIDTH-1:0] rd_adr;
   logic [ADDR_WIDTH-1:0] wr_adr;
   logic [BE_WIDTH-1:0]   wr_be;
   logic [WORD_WIDTH-1:0] wr_data;
   logic [WORD_WIDTH-1:0] wr_bmask;
   logic                  wr_ok;
   logic                  fwd;
   logic [WORD_WIDTH-1:0] rd_old;
   logic [WORD_WIDTH-1:0] rd_word;

   logic [WORD_WIDTH-1:0] mem [NUM_WORDS];

   always_comb begin
      rd_adr  = '0;
      wr_adr  = '0;
      wr_be   = '0;
      wr_data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (gnt_rd[c]) rd_adr = adr[c*ADDR_WIDTH +: ADDR_WIDTH];
         if (gnt_wr[c]) begin
            wr_adr  = adr[c*ADDR_WIDTH +: ADDR_WIDTH];
            wr_be   = be[c*BE_WIDTH +: BE_WIDTH];
            wr_data = datai[c*WORD_WIDTH +: WORD_WIDTH];
         end
      end
      // Lane b/8 also covers the short top lane when word_width is not a byte multiple.
      for (int b = 0; b < WORD_WIDTH; b++) begin
         wr_bmask[b] = wr_be[b/8];
      end
      rd_fire = |gnt_rd;
      wr_fire = |gnt_wr;
      wr_ok   = int'(wr_adr) < NUM_WORDS;
      fwd     = (TWO_PORT != 0) && rd_fire && wr_fire && (rd_adr == wr_adr);
      rd_old  = mem[rd_adr];
      rd_word = fwd ? ((rd_old & ~wr_bmask) | (wr_data & wr_bmask)) : rd_old;
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_fire && wr_ok) begin
         mem[wr_adr] <= (mem[wr_adr] & ~wr_bmask) | (wr_data & wr_bmask);
      end
   end

   logic [NUM_CH-1:0]     rvalid_q;
   logic [WORD_WIDTH-1:0] datao_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= '0;
         datao_q  <= '0;
      end else begin
         rvalid_q <= gnt_rd;
         if (rd_fire) datao_q <= rd_word;
      end
   end

`ifdef IP4_RAM_ARB_OREG_EN
   logic [NUM_CH-1:0]     rvalid_q2;
   logic [WORD_WIDTH-1:0] datao_q2;

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q2 <= '0;
         datao_q2  <= '0;
      end else begin
         rvalid_q2 <= rvalid_q;
         datao_q2  <= datao_q;
      end
   end

   assign rvalid = rvalid_q2;
   assign datao  = datao_q2;
`else
   assign rvalid = rvalid_q;
   assign datao  = datao_q;
`endif

endmodule
`default_nettype wire
